// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage pipeline: M/W forwarding, load-use and branch handling,
// plus a per-register scoreboard for results from the variable-latency long-op unit.
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int AW       = 5,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    RS1_D,
    input  logic [AW-1:0]    RS2_D,
    input  logic [AW-1:0]    RD_D,
    input  logic             UsesRs1D,
    input  logic             UsesRs2D,
    input  logic             RegWriteD,
    input  logic [AW-1:0]    RS1_E,
    input  logic [AW-1:0]    RS2_E,
    input  logic [AW-1:0]    RD_E,
    input  logic             ResultSrcE0,
    input  logic             LongIssueE,
    input  logic             LongBusy,
    input  logic             PCSrcE,
    input  logic             RegWriteM,
    input  logic [AW-1:0]    RD_M,
    input  logic             RegWriteW,
    input  logic [AW-1:0]    RD_W,
    input  logic             LongDoneW,
    input  logic [AW-1:0]    LongRdW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic [CNT_W-1:0] StallCnt
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                raw_stall;
    logic                waw_stall;
    logic                lw_stall;
    logic                struct_stall;

    // Registered busy bit, or the long op issuing from E right now (bypass for the issue cycle).
    function automatic logic busy_eff(input logic [NUM_REGS-1:0] b, input logic [AW-1:0] r,
                                      input logic issue, input logic [AW-1:0] rd_e);
        logic hit;
        hit = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (r == AW'(i)) hit = b[i];
        end
        if (issue && (rd_e == r) && (r != '0)) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (RegWriteM && (RD_M != '0) && (RD_M == rs))      sel = 2'b10;
        else if (RegWriteW && (RD_W != '0) && (RD_W == rs)) sel = 2'b01;
        return sel;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_comb begin
        raw_stall    = (UsesRs1D && busy_eff(busy, RS1_D, LongIssueE, RD_E)) ||
                       (UsesRs2D && busy_eff(busy, RS2_D, LongIssueE, RD_E));
        waw_stall    = RegWriteD && busy_eff(busy, RD_D, LongIssueE, RD_E);
        lw_stall     = ResultSrcE0 && (RD_E != '0) &&
                       ((UsesRs1D && (RS1_D == RD_E)) || (UsesRs2D && (RS2_D == RD_E)));
        struct_stall = LongIssueE && LongBusy;
    end

    // Outputs are forced low while reset is held.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        if (rst) begin
            ForwardAE = fwd_sel(RS1_E);
            ForwardBE = fwd_sel(RS2_E);
            StallE    = struct_stall;
            StallF    = struct_stall || lw_stall || raw_stall || waw_stall;
            StallD    = StallF;
            FlushM    = struct_stall;
            // E is held on a structural stall, so the bubble goes into M instead of E.
            FlushE    = !struct_stall && (lw_stall || raw_stall || waw_stall || PCSrcE);
            FlushD    = PCSrcE;
        end
    end

    // Set beats clear on the same register; x0 never becomes busy.
    always_comb begin
        busy_next = busy;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (LongDoneW && (LongRdW == AW'(i)))                busy_next[i] = 1'b0;
            if (LongIssueE && !StallE && (RD_E == AW'(i)))       busy_next[i] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= '0;
            StallCnt <= '0;
        end else begin
            busy <= busy_next;
            if (StallF) StallCnt <= sat_inc(StallCnt);
        end
    end

endmodule
